// File: rtl/cell_result_sink.sv
// Result sink for the cell processor: buffers processed RGB cells in a FIFO and
// presents them one at a time on a display register and seven-segment digit codes.
module cell_result_sink #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned CELL_W      = 24,
    parameter int unsigned HOLD_CYCLES = 100_000_000
) (
    input  logic                     SYSCLK,
    input  logic                     RST,
    input  logic                     cell_valid,
    input  logic [CELL_W-1:0]        cell_data,
    output logic                     cell_ready,
    input  logic                     mode_manual,
    input  logic                     advance,
    output logic [CELL_W-1:0]        disp_cell,
    output logic                     disp_valid,
    output logic [39:0]              digits,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned DWELL_W = $clog2(HOLD_CYCLES);

    localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   COUNT_FULL   = CNT_W'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;

    logic [CELL_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [0:0]         state;
    logic [0:0]         state_next;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwell_next;
    logic [CELL_W-1:0]  disp_cell_next;
    logic               disp_valid_next;
    logic [CNT_W-1:0]   count_next;
    logic [39:0]        digits_next;
    logic               advance_q;
    logic               mode_q;
    logic               push;
    logic               pop;
    logic               adv_rise;
    logic               mode_fall;
    logic               fifo_nonempty;

    assign push          = cell_valid && cell_ready;
    assign adv_rise      = advance && !advance_q;
    assign mode_fall     = mode_q && !mode_manual;
    assign fifo_nonempty = (fifo_count != '0);
    assign count_next    = fifo_count + CNT_W'(push) - CNT_W'(pop);

    // Display sequencing: first result straight from IDLE, then dwell or button stepping
    always_comb begin
        state_next      = state;
        dwell_next      = dwell;
        disp_cell_next  = disp_cell;
        disp_valid_next = disp_valid;
        pop             = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_nonempty) begin
                    pop             = 1'b1;
                    disp_valid_next = 1'b1;
                    dwell_next      = DWELL_RELOAD;
                    state_next      = SHOW;
                end
            end
            SHOW: begin
                if (mode_fall) begin
                    dwell_next = DWELL_RELOAD;
                end else if (mode_manual) begin
                    if (adv_rise && fifo_nonempty) begin
                        pop = 1'b1;
                    end
                end else if (dwell == '0) begin
                    if (fifo_nonempty) begin
                        pop        = 1'b1;
                        dwell_next = DWELL_RELOAD;
                    end
                end else begin
                    dwell_next = dwell - DWELL_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        if (pop) begin
            disp_cell_next = mem[rd_ptr];
        end
    end

    // Digit codes trail disp_cell by one cycle; blank until a result is shown
    always_comb begin
        digits_next = '0;
        if (disp_valid) begin
            digits_next = {1'b0, disp_cell[23:20], 1'b0, disp_cell[19:16], 5'd0,
                           1'b0, disp_cell[15:12], 1'b0, disp_cell[11:8],  5'd0,
                           1'b0, disp_cell[7:4],   1'b0, disp_cell[3:0]};
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!RST && push) begin
            mem[wr_ptr] <= cell_data;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            state      <= IDLE;
            dwell      <= '0;
            disp_cell  <= '0;
            disp_valid <= 1'b0;
            digits     <= '0;
            fifo_count <= '0;
            cell_ready <= 1'b1;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            advance_q  <= 1'b0;
            mode_q     <= 1'b0;
        end else begin
            state      <= state_next;
            dwell      <= dwell_next;
            disp_cell  <= disp_cell_next;
            disp_valid <= disp_valid_next;
            digits     <= digits_next;
            fifo_count <= count_next;
            // Ready tracks the count it is derived from, with no same-cycle bypass
            cell_ready <= (count_next < COUNT_FULL);
            overflow   <= overflow || (cell_valid && !cell_ready);
            advance_q  <= advance;
            mode_q     <= mode_manual;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cell_result_sink.sv
// Directed self-checking bench for cell_result_sink with a short dwell (8 cycles).
module tb_cell_result_sink;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CELL_W = 24;
    localparam int unsigned HOLD   = 8;

    logic              SYSCLK = 1'b0;
    logic              RST;
    logic              cell_valid;
    logic [CELL_W-1:0] cell_data;
    logic              cell_ready;
    logic              mode_manual;
    logic              advance;
    logic [CELL_W-1:0] disp_cell;
    logic              disp_valid;
    logic [39:0]       digits;
    logic [3:0]        fifo_count;
    logic              overflow;

    int n_checks = 0;
    int n_fail   = 0;

    cell_result_sink #(.DEPTH(DEPTH), .CELL_W(CELL_W), .HOLD_CYCLES(HOLD)) dut (
        .SYSCLK     (SYSCLK),
        .RST        (RST),
        .cell_valid (cell_valid),
        .cell_data  (cell_data),
        .cell_ready (cell_ready),
        .mode_manual(mode_manual),
        .advance    (advance),
        .disp_cell  (disp_cell),
        .disp_valid (disp_valid),
        .digits     (digits),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 SYSCLK = ~SYSCLK;

    task automatic tick;
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic do_reset(input logic manual);
        RST         = 1'b1;
        cell_valid  = 1'b0;
        cell_data   = '0;
        advance     = 1'b0;
        mode_manual = manual;
        tick;
        tick;
        RST = 1'b0;
    endtask

    task automatic press;
        advance = 1'b1;
        tick;
        advance = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        do_reset(1'b0);
        n_checks++; if (cell_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cell_ready); end
        n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_disp_valid: got %b want 0", disp_valid); end
        n_checks++; if (disp_cell !== 24'h0) begin n_fail++; $display("FAIL reset_disp_cell: got %h want 0", disp_cell); end
        n_checks++; if (digits !== 40'h0) begin n_fail++; $display("FAIL reset_digits: got %h want 0", digits); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_first_result;
        logic [39:0] exp_digits;
        exp_digits = {5'h0A, 5'h01, 5'h00, 5'h0B, 5'h02, 5'h00, 5'h0C, 5'h03};
        cell_valid = 1'b1;
        cell_data  = 24'hA1B2C3;
        tick;
        cell_valid = 1'b0;
        n_checks++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL first_count_push: got %0d want 1", fifo_count); end
        n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL first_not_yet_valid: got %b want 0", disp_valid); end
        tick;
        n_checks++; if (disp_cell !== 24'hA1B2C3) begin n_fail++; $display("FAIL first_disp_cell: got %h want a1b2c3", disp_cell); end
        n_checks++; if (disp_valid !== 1'b1) begin n_fail++; $display("FAIL first_disp_valid: got %b want 1", disp_valid); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL first_count_pop: got %0d want 0", fifo_count); end
        n_checks++; if (digits !== 40'h0) begin n_fail++; $display("FAIL first_digits_lag: got %h want 0", digits); end
        tick;
        n_checks++; if (digits !== exp_digits) begin n_fail++; $display("FAIL first_digits: got %h want %h", digits, exp_digits); end
    endtask

    task automatic test_overflow;
        logic [23:0] exp_v;
        do_reset(1'b1);
        cell_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cell_data = 24'h102030 + 24'(i * 37);
            tick;
            if (i == 8) begin
                n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL ovf_full_count: got %0d want 8", fifo_count); end
                n_checks++; if (cell_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_full_ready: got %b want 0", cell_ready); end
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_not_yet: got %b want 0", overflow); end
            end
        end
        cell_valid = 1'b0;
        n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL ovf_count_held: got %0d want 8", fifo_count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
        n_checks++; if (disp_cell !== 24'h102030) begin n_fail++; $display("FAIL ovf_disp0: got %h want 102030", disp_cell); end
        for (int k = 1; k <= 8; k++) begin
            press;
            exp_v = 24'h102030 + 24'(k * 37);
            n_checks++; if (disp_cell !== exp_v) begin n_fail++; $display("FAIL ovf_drain_%0d: got %h want %h", k, disp_cell, exp_v); end
        end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL ovf_drained: got %0d want 0", fifo_count); end
        n_checks++; if (cell_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_back: got %b want 1", cell_ready); end
        press;
        exp_v = 24'h102030 + 24'(8 * 37);
        n_checks++; if (disp_cell !== exp_v) begin n_fail++; $display("FAIL ovf_rejected_absent: got %h want %h", disp_cell, exp_v); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        RST = 1'b1;
        tick;
        RST = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b want 0", overflow); end
    endtask

    task automatic test_auto;
        logic [23:0] exp_v;
        do_reset(1'b0);
        cell_valid = 1'b1;
        cell_data  = 24'h111111;
        tick;
        cell_data = 24'h222222;
        tick;
        n_checks++; if (disp_cell !== 24'h111111) begin n_fail++; $display("FAIL auto_e1: got %h want 111111", disp_cell); end
        cell_data = 24'h333333;
        tick;
        cell_valid = 1'b0;
        n_checks++; if (fifo_count !== 4'd2) begin n_fail++; $display("FAIL auto_queued: got %0d want 2", fifo_count); end
        for (int n = 3; n <= 30; n++) begin
            tick;
            exp_v = (n < 9) ? 24'h111111 : (n < 17) ? 24'h222222 : 24'h333333;
            n_checks++; if (disp_cell !== exp_v) begin n_fail++; $display("FAIL auto_edge_%0d: got %h want %h", n, disp_cell, exp_v); end
        end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL auto_empty: got %0d want 0", fifo_count); end
        n_checks++; if (disp_valid !== 1'b1) begin n_fail++; $display("FAIL auto_valid_hold: got %b want 1", disp_valid); end
        // dwell has expired; a manual excursion must restart the full dwell on return
        mode_manual = 1'b1;
        tick;
        tick;
        mode_manual = 1'b0;
        tick;
        cell_valid = 1'b1;
        cell_data  = 24'h444444;
        tick;
        cell_valid = 1'b0;
        for (int n = 2; n <= 8; n++) begin
            tick;
            exp_v = (n < 8) ? 24'h333333 : 24'h444444;
            n_checks++; if (disp_cell !== exp_v) begin n_fail++; $display("FAIL auto_reload_%0d: got %h want %h", n, disp_cell, exp_v); end
        end
    endtask

    task automatic test_manual;
        do_reset(1'b1);
        cell_valid = 1'b1;
        cell_data  = 24'hAAAAAA;
        tick;
        cell_data = 24'hBBBBBB;
        tick;
        cell_data = 24'hCCCCCC;
        tick;
        cell_valid = 1'b0;
        n_checks++; if (fifo_count !== 4'd2) begin n_fail++; $display("FAIL man_queued: got %0d want 2", fifo_count); end
        n_checks++; if (disp_cell !== 24'hAAAAAA) begin n_fail++; $display("FAIL man_first: got %h want aaaaaa", disp_cell); end
        advance = 1'b1;
        for (int n = 0; n < 20; n++) tick;
        advance = 1'b0;
        tick;
        n_checks++; if (disp_cell !== 24'hBBBBBB) begin n_fail++; $display("FAIL man_one_step: got %h want bbbbbb", disp_cell); end
        n_checks++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL man_one_step_count: got %0d want 1", fifo_count); end
        press;
        n_checks++; if (disp_cell !== 24'hCCCCCC) begin n_fail++; $display("FAIL man_second: got %h want cccccc", disp_cell); end
        press;
        n_checks++; if (disp_cell !== 24'hCCCCCC) begin n_fail++; $display("FAIL man_empty_press: got %h want cccccc", disp_cell); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL man_empty_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_back_to_back;
        logic [23:0] exp_v;
        do_reset(1'b1);
        cell_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cell_data = 24'h500000 + 24'(i);
            tick;
        end
        n_checks++; if (fifo_count !== 4'd4) begin n_fail++; $display("FAIL b2b_count4: got %0d want 4", fifo_count); end
        cell_data = 24'h500005;
        advance   = 1'b1;
        tick;
        cell_valid = 1'b0;
        advance    = 1'b0;
        n_checks++; if (fifo_count !== 4'd4) begin n_fail++; $display("FAIL b2b_pushpop_count: got %0d want 4", fifo_count); end
        n_checks++; if (disp_cell !== 24'h500001) begin n_fail++; $display("FAIL b2b_pushpop_disp: got %h want 500001", disp_cell); end
        tick;
        for (int k = 2; k <= 5; k++) begin
            press;
            exp_v = 24'h500000 + 24'(k);
            n_checks++; if (disp_cell !== exp_v) begin n_fail++; $display("FAIL b2b_order_%0d: got %h want %h", k, disp_cell, exp_v); end
        end
        for (int i = 0; i < 20; i++) begin
            exp_v = 24'hC00000 + 24'(i * 4099);
            cell_valid = 1'b1;
            cell_data  = exp_v;
            tick;
            cell_valid = 1'b0;
            n_checks++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL wrap_count_%0d: got %0d want 1", i, fifo_count); end
            press;
            n_checks++; if (disp_cell !== exp_v) begin n_fail++; $display("FAIL wrap_data_%0d: got %h want %h", i, disp_cell, exp_v); end
        end
    endtask

    task automatic test_reset_mid;
        do_reset(1'b0);
        cell_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cell_data = 24'h700000 + 24'(i);
            tick;
        end
        cell_valid = 1'b0;
        tick;
        tick;
        n_checks++; if (fifo_count !== 4'd5) begin n_fail++; $display("FAIL mid_buffered: got %0d want 5", fifo_count); end
        RST = 1'b1;
        tick;
        RST = 1'b0;
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
        n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_disp_valid: got %b want 0", disp_valid); end
        n_checks++; if (disp_cell !== 24'h0) begin n_fail++; $display("FAIL mid_disp_cell: got %h want 0", disp_cell); end
        n_checks++; if (digits !== 40'h0) begin n_fail++; $display("FAIL mid_digits: got %h want 0", digits); end
        n_checks++; if (cell_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", cell_ready); end
        tick;
        n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stays_empty: got %b want 0", disp_valid); end
        cell_valid = 1'b1;
        cell_data  = 24'h0F0F0F;
        tick;
        cell_valid = 1'b0;
        tick;
        n_checks++; if (disp_cell !== 24'h0F0F0F) begin n_fail++; $display("FAIL mid_fresh: got %h want 0f0f0f", disp_cell); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL mid_fresh_count: got %0d want 0", fifo_count); end
    endtask

    initial begin
        test_reset;
        test_first_result;
        test_overflow;
        test_auto;
        test_manual;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
